// File: rtl/pet_stats_if.sv
// Bundle between the pet-statistics engine and its neighbours: UART command
// byte and LFSR value in, stat vector, tick/heartbeat, command ack and life state out.
interface pet_stats_if #(
    parameter int NUM_STATS = 6,
    parameter int STAT_W    = 4
);
    logic [7:0]                  inputs;
    logic [7:0]                  random;
    logic [NUM_STATS*STAT_W-1:0] stats;
    logic                        tick;
    logic                        heartbeat;
    logic                        cmd_ack;
    logic [1:0]                  life_state;

    modport master (
        output inputs, random,
        input  stats, tick, heartbeat, cmd_ack, life_state
    );

    modport slave (
        input  inputs, random,
        output stats, tick, heartbeat, cmd_ack, life_state
    );
endinterface

// File: rtl/pet_stats_engine.sv
// Saturating pet need counters: random stat raised every divided tick, UART
// commands lower a stat once per key press, life FSM tracks ALIVE/WARN/DEAD.
module pet_stats_engine #(
    parameter int NUM_STATS   = 6,
    parameter int STAT_W      = 4,
    parameter int TICK_DIV    = 27000000,
    parameter int CARE_STEP   = 1,
    parameter int DEATH_TICKS = 8
) (
    input  logic      clk,
    input  logic      reset,
    pet_stats_if.slave bus
);

    localparam int IW    = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DC_W  = $clog2(DEATH_TICKS + 1);

    localparam logic [STAT_W-1:0] SMAX     = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STEP     = STAT_W'(CARE_STEP);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DC_W-1:0]   DC_LIMIT = DC_W'(DEATH_TICKS);

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        WARN  = 2'd1,
        DEAD  = 2'd2
    } life_t;

    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic [STAT_W-1:0] stat_q [NUM_STATS];
    logic [STAT_W-1:0] stat_d [NUM_STATS];
    logic              any_max;
    logic              armed_q;
    logic              cmd_ack_q;
    logic              heartbeat_q;
    life_t             state_q, state_d;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic [DC_W-1:0]   dcnt_inc;
    logic              cmd_hit;
    logic [IW-1:0]     cmd_idx;
    logic              cmd_accept;
    logic [IW-1:0]     tick_idx;
    logic              inc_en;
    logic              unused_random;

    // ---------------- tick divider ----------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update together from pre-edge values; blocking here would create races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_LAST);

    // ---------------- command decode ----------------
    // NOTE: combinational outputs get a default before any branch so no path
    // leaves them unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cmd_hit = 1'b0;
        cmd_idx = '0;
        for (int i = 0; i < NUM_STATS; i++) begin
            if (bus.inputs == 8'(8'h30 + i)) begin
                cmd_hit = 1'b1;
                cmd_idx = IW'(i);
            end
        end
        if (bus.inputs == 8'h65) begin
            cmd_hit = 1'b1;
            cmd_idx = '0;
        end
        if (NUM_STATS >= 2 && bus.inputs == 8'h73) begin
            cmd_hit = 1'b1;
            cmd_idx = IW'(1);
        end
    end

    assign cmd_accept = cmd_hit && armed_q && (state_q != DEAD);

    // Indices at or above NUM_STATS match no counter, so the tick is a no-op.
    assign tick_idx      = bus.random[IW-1:0];
    assign unused_random = ^bus.random[7:IW];
    assign inc_en        = tick && (state_q != DEAD);

    // Increment (saturating) first, then subtract, so collisions cancel out.
    always_comb begin
        any_max = 1'b0;
        for (int i = 0; i < NUM_STATS; i++) begin
            stat_d[i] = stat_q[i];
            if (inc_en && tick_idx == IW'(i) && stat_d[i] != SMAX) begin
                stat_d[i] = stat_d[i] + 1'b1;
            end
            if (cmd_accept && cmd_idx == IW'(i)) begin
                stat_d[i] = (stat_d[i] > STEP) ? stat_d[i] - STEP : '0;
            end
            if (stat_d[i] == SMAX) begin
                any_max = 1'b1;
            end
        end
    end

    // NOTE: the stat array is a small bank of flops, not a RAM, so every entry
    // can and must be cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STATS; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    // A held key acts once; an idle byte re-arms, other bytes leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q     <= 1'b1;
            cmd_ack_q   <= 1'b0;
            heartbeat_q <= 1'b0;
        end else begin
            cmd_ack_q <= cmd_accept;
            if (tick) begin
                heartbeat_q <= ~heartbeat_q;
            end
            if (bus.inputs == 8'h00) begin
                armed_q <= 1'b1;
            end else if (cmd_accept) begin
                armed_q <= 1'b0;
            end
        end
    end

    // ---------------- life FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ALIVE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign dcnt_inc = dcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (tick) begin
            unique case (state_q)
                ALIVE: begin
                    if (any_max) begin
                        dcnt_d  = DC_W'(1);
                        state_d = (DEATH_TICKS == 1) ? DEAD : WARN;
                    end
                end
                WARN: begin
                    if (any_max) begin
                        dcnt_d = dcnt_inc;
                        if (dcnt_inc >= DC_LIMIT) begin
                            state_d = DEAD;
                        end
                    end else begin
                        dcnt_d  = '0;
                        state_d = ALIVE;
                    end
                end
                DEAD:    state_d = DEAD;
                default: state_d = ALIVE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.stats = '0;
        for (int i = 0; i < NUM_STATS; i++) begin
            bus.stats[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end

    assign bus.tick       = tick;
    assign bus.heartbeat  = heartbeat_q;
    assign bus.cmd_ack    = cmd_ack_q;
    assign bus.life_state = state_q;

endmodule
